serial_mac_engine: RTL and testbench

Parametrised successor to the single-channel serial feature/weight loader plus PE.
- Sequentially fetches one feature vector and NUM_CH weight vectors from a shared single-port memory.
- Computes one signed dot product per output channel in a wide accumulator, then scales, saturates or wraps, and writes each result back to memory.
- Sits between the memory controller and the top-level mode mux, and is driven by a start/done handshake.

---
 rtl/serial_mac_pkg.sv | 35 +++
 rtl/mac_acc_unit.sv | 60 ++++++
 rtl/serial_mac_engine.sv | 206 ++++++++++++++++++++
 tb/tb_serial_mac_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mac_pkg.sv
// Shared types and helpers for the serial multiply-accumulate engine:
// FSM state encoding, accumulator sizing and result saturation.
package serial_mac_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_W = 3'd1,
        FETCH_F = 3'd2,
        MAC     = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Headroom for VEC_LEN full-scale products plus one guard bit.
    function automatic int acc_width(input int data_w, input int vec_len);
        return 2 * data_w + $clog2(vec_len) + 1;
    endfunction

    // Clamp a sign-extended value into the signed range of a data_w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Datapath of the engine: weight holding register, signed multiply-accumulate
// and the shift + saturate/wrap narrowing of the accumulator.
module mac_acc_unit
    import serial_mac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_w,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] q,
    input  logic              sat_mode,
    input  logic [3:0]        out_shift,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = acc_width(DATA_W, VEC_LEN);

    logic signed [DATA_W-1:0]   w_reg_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    shifted_s;
    logic signed [63:0]         wide_s;

    assign prod_s     = w_reg_r * $signed(q);
    assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};

    // Weight capture and accumulation; clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg_r <= '0;
            acc_r   <= '0;
        end else begin
            if (load_w) begin
                w_reg_r <= $signed(q);
            end
            if (clr) begin
                acc_r <= '0;
            end else if (acc_en) begin
                acc_r <= acc_r + prod_ext_s;
            end
        end
    end

    // Arithmetic shift, then either clamp or keep the low bits.
    always_comb begin
        shifted_s = acc_r >>> out_shift;
        wide_s    = {{(64-ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
        if (sat_mode) begin
            result = DATA_W'(saturate(wide_s, DATA_W));
        end else begin
            result = shifted_s[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/serial_mac_engine.sv
// Multi-channel serial dot-product engine: fetches a feature vector and NUM_CH
// weight vectors from a single-port memory and writes one result per channel.
module serial_mac_engine
    import serial_mac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int VEC_LEN = 4,
    parameter int NUM_CH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              sat_mode,
    input  logic [3:0]        out_shift,
    input  logic [ADDR_W-1:0] feature_baseaddr,
    input  logic [ADDR_W-1:0] weight_baseaddr,
    input  logic [ADDR_W-1:0] result_baseaddr,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              is_done_o
);

    localparam int KW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(VEC_LEN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);

    state_t            state_r, state_s;
    logic [KW-1:0]     k_r;
    logic [CW-1:0]     ch_r;
    logic [ADDR_W-1:0] fbase_r, wbase_r, rbase_r;
    logic              sat_r;
    logic [3:0]        shift_r;
    logic              busy_r, done_r;

    logic              clr_s, load_w_s, acc_en_s, we_s;
    logic [ADDR_W-1:0] addr_s, w_addr_s, f_addr_s, r_addr_s;
    logic [DATA_W-1:0] wdata_s, result_s;

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign w_addr_s = wbase_r + ADDR_W'(32'(ch_r) * VEC_LEN) + ADDR_W'(k_r);
    assign f_addr_s = fbase_r + ADDR_W'(k_r);
    assign r_addr_s = rbase_r + ADDR_W'(ch_r);

    mac_acc_unit #(
        .DATA_W  (DATA_W),
        .VEC_LEN (VEC_LEN)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (clr_s),
        .load_w    (load_w_s),
        .acc_en    (acc_en_s),
        .q         (q),
        .sat_mode  (sat_r),
        .out_shift (shift_r),
        .result    (result_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, datapath strobes and memory port; every strobe is qualified by en.
    always_comb begin
        state_s  = state_r;
        clr_s    = 1'b0;
        load_w_s = 1'b0;
        acc_en_s = 1'b0;
        we_s     = 1'b0;
        addr_s   = '0;
        wdata_s  = '0;
        case (state_r)
            IDLE: begin
                if (start && en) begin
                    clr_s   = 1'b1;
                    state_s = FETCH_W;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH_W: begin
                addr_s = w_addr_s;
                if (en) begin
                    state_s = FETCH_F;
                end else begin
                    state_s = FETCH_W;
                end
            end
            FETCH_F: begin
                addr_s = f_addr_s;
                if (en) begin
                    load_w_s = 1'b1;
                    state_s  = MAC;
                end else begin
                    state_s = FETCH_F;
                end
            end
            MAC: begin
                // Feature address kept up so q stays stable through a stall.
                addr_s = f_addr_s;
                if (en) begin
                    acc_en_s = 1'b1;
                    if (k_r == K_LAST) begin
                        state_s = WRITE;
                    end else begin
                        state_s = FETCH_W;
                    end
                end else begin
                    state_s = MAC;
                end
            end
            WRITE: begin
                addr_s  = r_addr_s;
                wdata_s = result_s;
                we_s    = en;
                if (en) begin
                    if (ch_r == C_LAST) begin
                        state_s = DONE;
                    end else begin
                        clr_s   = 1'b1;
                        state_s = FETCH_W;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            DONE: begin
                if (en) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Counters, latched run configuration and the busy/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_r     <= '0;
            ch_r    <= '0;
            fbase_r <= '0;
            wbase_r <= '0;
            rbase_r <= '0;
            sat_r   <= 1'b0;
            shift_r <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (en) begin
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        fbase_r <= feature_baseaddr;
                        wbase_r <= weight_baseaddr;
                        rbase_r <= result_baseaddr;
                        sat_r   <= sat_mode;
                        shift_r <= out_shift;
                        k_r     <= '0;
                        ch_r    <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                MAC: begin
                    if (k_r != K_LAST) begin
                        k_r <= k_r + KW'(1'b1);
                    end
                end
                WRITE: begin
                    if (ch_r != C_LAST) begin
                        ch_r <= ch_r + CW'(1'b1);
                        k_r  <= '0;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end else begin
            done_r <= 1'b0;
        end
    end

    assign addr      = addr_s;
    assign we        = we_s;
    assign wdata     = wdata_s;
    assign busy      = busy_r;
    assign is_done_o = done_r;

endmodule

// File: tb/tb_serial_mac_engine.sv
// Directed bench for serial_mac_engine: table of dot-product runs against a
// behavioural memory, plus stall and mid-run reset sequences.
module tb_serial_mac_engine;

    localparam logic [5:0] WB = 6'd8;
    localparam logic [5:0] RB = 6'd20;

    typedef struct {
        logic [0:3][7:0] f;
        logic [0:3][7:0] w0;
        logic [0:3][7:0] w1;
        logic [3:0]      sh;
        logic            sat;
        logic [5:0]      fb;
        logic [7:0]      e0;
        logic [7:0]      e1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, start, sat_mode, we, busy, is_done_o;
    logic [3:0] out_shift;
    logic [5:0] feature_baseaddr, weight_baseaddr, result_baseaddr, addr;
    logic [7:0] q, wdata;

    logic [7:0] mem [64];
    logic       ld_en = 1'b0;
    logic [5:0] ld_addr = 6'd0;
    logic [7:0] ld_data = 8'd0;

    int cyc = 0;
    int start_cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl [8];

    serial_mac_engine dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .start            (start),
        .sat_mode         (sat_mode),
        .out_shift        (out_shift),
        .feature_baseaddr (feature_baseaddr),
        .weight_baseaddr  (weight_baseaddr),
        .result_baseaddr  (result_baseaddr),
        .q                (q),
        .addr             (addr),
        .we               (we),
        .wdata            (wdata),
        .busy             (busy),
        .is_done_o        (is_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with one-cycle read latency and a bench-side load port.
    always @(posedge clk) begin
        q <= mem[addr];
        if (we) mem[addr] <= wdata;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    function automatic vec_t mk(input logic [31:0] f, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [3:0] sh,
                                input logic sat, input logic [5:0] fb,
                                input logic [7:0] e0, input logic [7:0] e1);
        vec_t v;
        v.f = f; v.w0 = w0; v.w1 = w1; v.sh = sh; v.sat = sat;
        v.fb = fb; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic mem_wr(input logic [5:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            mem_wr(v.fb + 6'(i), v.f[i]);
            mem_wr(WB + 6'(i), v.w0[i]);
            mem_wr(WB + 6'd4 + 6'(i), v.w1[i]);
        end
        mem_wr(RB, 8'hAA);
        mem_wr(RB + 6'd1, 8'hAA);
    endtask

    // Start pulse; inputs are scrambled afterwards to prove they were latched.
    task automatic do_start(input vec_t v);
        en               = 1'b1;
        sat_mode         = v.sat;
        out_shift        = v.sh;
        feature_baseaddr = v.fb;
        start            = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc        = cyc;
        sat_mode         = ~v.sat;
        out_shift        = 4'hF;
        feature_baseaddr = 6'd33;
    endtask

    task automatic wait_done(input bit poke, output int lat, output int busy_low);
        lat = -1;
        busy_low = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (is_done_o) begin
                lat = cyc - start_cyc;
                break;
            end
            if (!busy) busy_low++;
            if (poke) start = (i % 5 == 2);
        end
        start = 1'b0;
        if (lat < 0) $display("FAIL timeout: is_done_o not seen within 200 cycles");
    endtask

    initial begin
        int lat, bl;

        rst = 1'b0; en = 1'b1; start = 1'b0; sat_mode = 1'b0; out_shift = 4'd0;
        feature_baseaddr = 6'd0; weight_baseaddr = WB; result_baseaddr = RB;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", addr, 0);
        check("rst_we", we, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", is_done_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        tbl[0] = mk(32'h01020304, 32'h01010101, 32'h0200FF01, 4'd0, 1'b1, 6'd0,  8'h0A, 8'h03);
        tbl[1] = mk(32'h01020304, 32'h7F7F7F7F, 32'h00000000, 4'd0, 1'b1, 6'd0,  8'h7F, 8'h00);
        tbl[2] = mk(32'h01020304, 32'h7F7F7F7F, 32'h01000000, 4'd0, 1'b0, 6'd0,  8'hF6, 8'h01);
        tbl[3] = mk(32'h01020304, 32'h7F7F7F7F, 32'hFFFFFFFF, 4'd3, 1'b1, 6'd0,  8'h7F, 8'hFE);
        tbl[4] = mk(32'h7F7F7F7F, 32'h80808080, 32'h80808080, 4'd0, 1'b1, 6'd0,  8'h80, 8'h80);
        tbl[5] = mk(32'h7F7F7F7F, 32'h80808080, 32'h01010101, 4'd0, 1'b0, 6'd0,  8'h00, 8'hFC);
        tbl[6] = mk(32'h05FD0702, 32'h01020304, 32'hFF0101FF, 4'd0, 1'b1, 6'd62, 8'h1C, 8'hFD);
        tbl[7] = mk(32'h01020304, 32'hFFFFFFFF, 32'h0200FF01, 4'd1, 1'b0, 6'd0,  8'hFB, 8'h01);

        for (int t = 0; t < 8; t++) begin
            load(tbl[t]);
            do_start(tbl[t]);
            wait_done(1'b0, lat, bl);
            check($sformatf("v%0d_latency", t), lat, 27);
            check($sformatf("v%0d_busy_gap", t), bl, 0);
            check($sformatf("v%0d_busy_at_done", t), busy, 0);
            check($sformatf("v%0d_res0", t), mem[RB], tbl[t].e0);
            check($sformatf("v%0d_res1", t), mem[RB + 6'd1], tbl[t].e1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", t), is_done_o, 0);
        end

        // Stall five cycles in ch0 MAC and five in ch0 WRITE.
        load(tbl[0]);
        do_start(tbl[0]);
        repeat (2) begin @(posedge clk); #1; end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_mac_we", we, 0);
        end
        en = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("write_we", we, 1);
        check("write_addr", addr, RB);
        en = 1'b0;
        #1;
        check("stall_write_we", we, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_write_we_hold", we, 0);
            check("stall_write_addr_hold", addr, RB);
        end
        en = 1'b1;
        #1;
        check("write_resume_we", we, 1);
        wait_done(1'b0, lat, bl);
        check("stall_latency", lat, 37);
        check("stall_res0", mem[RB], 8'h0A);
        check("stall_res1", mem[RB + 6'd1], 8'h03);

        // Asynchronous reset during ch1 MAC, then a clean run with ignored starts.
        load(tbl[6]);
        do_start(tbl[6]);
        repeat (15) begin @(posedge clk); #1; end
        check("pre_rst_addr", addr, 62);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_addr", addr, 0);
        check("midrst_we", we, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", is_done_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        load(tbl[1]);
        do_start(tbl[1]);
        wait_done(1'b1, lat, bl);
        check("rerun_latency", lat, 27);
        check("rerun_busy_gap", bl, 0);
        check("rerun_res0", mem[RB], 8'h7F);
        check("rerun_res1", mem[RB + 6'd1], 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rerun_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
